gpsreceiver2_sampler: RTL and testbench

//  Front-end sample capture stage, directly upstream of the GPS receiver CSR interface.

---
 rtl/gpsreceiver2_sampler_pkg.sv | 32 +++
 rtl/gpsreceiver2_sampler_if.sv | 29 ++
 rtl/gpsreceiver2_fifo.sv | 73 +++++++
 rtl/gpsreceiver2_sampler.sv | 108 ++++++++++
 tb/tb_gpsreceiver2_sampler.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpsreceiver2_sampler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpsreceiver2_sampler_pkg
//  Purpose  : Shared sample/word geometry and FIFO entry type for the sampler.
//  Revision : 1.0
// ============================================================================
package gpsreceiver2_sampler_pkg;

    localparam int c_sample_w          = 2;
    localparam int c_samples_per_word  = 16;
    localparam int c_word_w            = c_sample_w * c_samples_per_word;
    localparam int c_count_w           = 11;
    localparam int c_default_epoch_len = 2046;

    typedef struct packed {
        logic                first;
        logic [c_word_w-1:0] data;
    } word_entry_t;

    // Sign lands in the odd bit, magnitude in the even bit of the slot.
    function automatic logic [c_word_w-1:0] place_sample(
        input logic       sign,
        input logic       mag,
        input logic [3:0] slot
    );
        logic [c_word_w-1:0] placed;
        placed = {{(c_word_w-2){1'b0}}, sign, mag};
        return placed << {slot, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpsreceiver2_sampler_if.sv
`default_nettype none
// ============================================================================
//  Module   : gpsreceiver2_sampler_if
//  Purpose  : Sample strobe input and packed-word valid/ready stream.
//  Revision : 1.0
// ============================================================================
interface gpsreceiver2_sampler_if;
    import gpsreceiver2_sampler_pkg::*;

    logic                sample_stb;
    logic                sample_sign;
    logic                sample_mag;
    logic                word_valid;
    logic                word_ready;
    logic [c_word_w-1:0] word_data;
    logic                word_first;

    modport master (
        output sample_stb, sample_sign, sample_mag, word_ready,
        input  word_valid, word_data, word_first
    );

    modport slave (
        input  sample_stb, sample_sign, sample_mag, word_ready,
        output word_valid, word_data, word_first
    );

endinterface
`default_nettype wire

// File: rtl/gpsreceiver2_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : gpsreceiver2_fifo
//  Purpose  : Count-based synchronous word FIFO; a push into a full FIFO is
//             accepted when a pop happens in the same cycle.
//  Revision : 1.0
// ============================================================================
module gpsreceiver2_fifo
    import gpsreceiver2_sampler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  i_push,
    input  word_entry_t i_push_data,
    input  wire logic  i_pop,
    output logic       o_head_valid,
    output word_entry_t o_head_data,
    output logic       o_drop
);

    localparam int              c_ptr_w      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w+1)'(DEPTH);

    word_entry_t          r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_count);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_do_push & ~w_do_pop) begin
                r_count <= r_count + (c_ptr_w+1)'(1);
            end else if (~w_do_push & w_do_pop) begin
                r_count <= r_count - (c_ptr_w+1)'(1);
            end
        end
    end

    // Storage needs no reset: the head is only observed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_valid = ~w_empty;
    assign o_head_data  = r_mem[r_rd_ptr];
    assign o_drop       = i_push & ~w_do_push;

endmodule
`default_nettype wire

// File: rtl/gpsreceiver2_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : gpsreceiver2_sampler
//  Purpose  : Counts 2-bit samples modulo one epoch, packs 16 per word with an
//             epoch-aligned flush, and streams words out through a small FIFO.
//  Revision : 1.0
// ============================================================================
module gpsreceiver2_sampler
    import gpsreceiver2_sampler_pkg::*;
#(
    parameter int EPOCH_LEN  = c_default_epoch_len,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                 sys_clk,
    input  wire logic                 sys_rst,
    input  wire logic                 enable,
    input  wire logic                 soft_reset,
    gpsreceiver2_sampler_if.slave     stream,
    output logic [c_count_w-1:0]      rx_count,
    output logic                      epoch,
    output logic                      overflow
);

    localparam logic [c_count_w-1:0] c_last_idx  = c_count_w'(EPOCH_LEN - 1);
    localparam logic [3:0]           c_last_slot = 4'(c_samples_per_word - 1);

    logic [c_count_w-1:0] r_rx_count;
    logic                 r_epoch;
    logic [3:0]           r_fill;
    logic [c_word_w-1:0]  r_pack;
    logic                 r_first_pending;
    logic                 r_done;
    word_entry_t          r_done_entry;
    logic                 r_overflow;

    logic                 w_clr;
    logic                 w_accept;
    logic                 w_wrap;
    logic                 w_word_done;
    logic [c_word_w-1:0]  w_pack_next;
    logic                 w_pop;
    logic                 w_head_valid;
    word_entry_t          w_head;
    logic                 w_drop;

    assign w_clr       = sys_rst | soft_reset;
    assign w_accept    = stream.sample_stb & enable & ~soft_reset;
    assign w_wrap      = (r_rx_count == c_last_idx);
    assign w_word_done = w_accept & ((r_fill == c_last_slot) | w_wrap);
    assign w_pack_next = r_pack | place_sample(stream.sample_sign, stream.sample_mag, r_fill);

    always_ff @(posedge sys_clk) begin
        if (w_clr) begin
            r_rx_count      <= '0;
            r_epoch         <= 1'b0;
            r_fill          <= '0;
            r_pack          <= '0;
            r_first_pending <= 1'b1;
            r_done          <= 1'b0;
            r_done_entry    <= '0;
            r_overflow      <= 1'b0;
        end else begin
            r_epoch <= w_accept & w_wrap;
            r_done  <= w_word_done;
            if (w_accept) begin
                r_rx_count <= w_wrap ? '0 : r_rx_count + c_count_w'(1);
                if (w_word_done) begin
                    r_done_entry.first <= r_first_pending;
                    r_done_entry.data  <= w_pack_next;
                    r_pack             <= '0;
                    r_fill             <= '0;
                    // A flush at the epoch's last sample makes the next word the epoch's first.
                    r_first_pending    <= w_wrap;
                end else begin
                    r_pack <= w_pack_next;
                    r_fill <= r_fill + 4'd1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    gpsreceiver2_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (sys_clk),
        .rst          (w_clr),
        .i_push       (r_done),
        .i_push_data  (r_done_entry),
        .i_pop        (w_pop),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head),
        .o_drop       (w_drop)
    );

    assign w_pop             = w_head_valid & stream.word_ready;
    assign stream.word_valid = w_head_valid;
    assign stream.word_data  = w_head_valid ? w_head.data : '0;
    assign stream.word_first = w_head_valid & w_head.first;

    assign rx_count = r_rx_count;
    assign epoch    = r_epoch;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_gpsreceiver2_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpsreceiver2_sampler
//  Purpose  : Directed self-checking bench for gpsreceiver2_sampler.
//  Revision : 1.0
// ============================================================================
module tb_gpsreceiver2_sampler;
    import gpsreceiver2_sampler_pkg::*;

    localparam int EPOCH_LEN = 2046;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        enable;
    logic        soft_reset;
    logic [10:0] rx_count;
    logic        epoch;
    logic        overflow;
    int          total = 0;
    int          bad   = 0;

    gpsreceiver2_sampler_if bus ();

    gpsreceiver2_sampler #(
        .EPOCH_LEN  (EPOCH_LEN),
        .FIFO_DEPTH (4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .soft_reset (soft_reset),
        .stream     (bus),
        .rx_count   (rx_count),
        .epoch      (epoch),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // One strobe; consecutive calls give back-to-back strobes.
    task automatic send(input logic [1:0] v);
        bus.sample_stb  = 1'b1;
        bus.sample_sign = v[1];
        bus.sample_mag  = v[0];
        tick();
        bus.sample_stb  = 1'b0;
    endtask

    task automatic send_word(input int w, output logic [31:0] exp);
        logic [1:0] v;
        exp = '0;
        for (int k = 0; k < 16; k++) begin
            v   = 2'((w + k) % 4);
            exp = exp | (32'(v) << (2 * k));
            send(v);
        end
    endtask

    task automatic do_soft_reset;
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
    endtask

    task automatic test_reset;
        sys_rst        = 1'b1;
        enable         = 1'b1;
        soft_reset     = 1'b0;
        bus.sample_stb = 1'b0;
        bus.sample_sign = 1'b0;
        bus.sample_mag = 1'b0;
        bus.word_ready = 1'b0;
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();
        total++; if (rx_count !== 11'd0) begin bad++; $display("FAIL reset_rx_count got=%0d want=0", rx_count); end
        total++; if (epoch !== 1'b0) begin bad++; $display("FAIL reset_epoch got=%b want=0", epoch); end
        total++; if (bus.word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.word_valid); end
        total++; if (bus.word_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.word_data); end
        total++; if (bus.word_first !== 1'b0) begin bad++; $display("FAIL reset_first got=%b want=0", bus.word_first); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_single_word;
        bus.word_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(2'b10);
        total++; if (bus.word_valid !== 1'b0) begin bad++; $display("FAIL single_valid_early got=%b want=0", bus.word_valid); end
        total++; if (rx_count !== 11'd16) begin bad++; $display("FAIL single_rx_count got=%0d want=16", rx_count); end
        tick();
        total++; if (bus.word_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus.word_valid); end
        total++; if (bus.word_data !== 32'hAAAAAAAA) begin bad++; $display("FAIL single_data got=%h want=aaaaaaaa", bus.word_data); end
        total++; if (bus.word_first !== 1'b1) begin bad++; $display("FAIL single_first got=%b want=1", bus.word_first); end
        tick();
    endtask

    task automatic test_epoch;
        int          nwords = 0;
        int          nep = 0;
        int          ep_at = -1;
        int          mid_errs = 0;
        logic [10:0] rxc_at = 11'h7FF;
        logic [31:0] d127 = '0;
        logic        f128 = 1'b0;
        logic [31:0] exp_d;
        logic        exp_f;
        do_soft_reset();
        bus.word_ready = 1'b1;
        for (int i = 0; i < EPOCH_LEN + 16 + 3; i++) begin
            if (i < EPOCH_LEN + 16) send(2'b11);
            else tick();
            if (epoch === 1'b1) begin
                nep++;
                ep_at  = i;
                rxc_at = rx_count;
            end
            if (bus.word_valid === 1'b1) begin
                exp_d = (nwords == 127) ? 32'h0FFFFFFF : 32'hFFFFFFFF;
                exp_f = (nwords == 0) || (nwords == 128);
                if (nwords == 127) d127 = bus.word_data;
                if (nwords == 128) f128 = bus.word_first;
                if (bus.word_data !== exp_d || bus.word_first !== exp_f) mid_errs++;
                nwords++;
            end
        end
        total++; if (nep != 1) begin bad++; $display("FAIL epoch_pulses got=%0d want=1", nep); end
        total++; if (ep_at != EPOCH_LEN - 1) begin bad++; $display("FAIL epoch_position got=%0d want=%0d", ep_at, EPOCH_LEN - 1); end
        total++; if (rxc_at !== 11'd0) begin bad++; $display("FAIL epoch_rx_wrap got=%0d want=0", rxc_at); end
        total++; if (nwords != 129) begin bad++; $display("FAIL epoch_word_count got=%0d want=129", nwords); end
        total++; if (d127 !== 32'h0FFFFFFF) begin bad++; $display("FAIL epoch_flush_word got=%h want=0fffffff", d127); end
        total++; if (f128 !== 1'b1) begin bad++; $display("FAIL epoch_next_first got=%b want=1", f128); end
        total++; if (mid_errs != 0) begin bad++; $display("FAIL epoch_word_stream got=%0d errors want=0", mid_errs); end
        total++; if (rx_count !== 11'd16) begin bad++; $display("FAIL epoch_rx_after got=%0d want=16", rx_count); end
    endtask

    task automatic test_overflow;
        logic [31:0] e [6];
        do_soft_reset();
        bus.word_ready = 1'b0;
        for (int w = 0; w < 5; w++) send_word(w, e[w]);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b want=0", overflow); end
        tick();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
        send_word(5, e[5]);
        tick();
        tick();
        total++; if (bus.word_data !== e[0] || bus.word_first !== 1'b1) begin bad++; $display("FAIL ovf_head_held got=%h/%b want=%h/1", bus.word_data, bus.word_first, e[0]); end
        bus.word_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            total++; if (bus.word_valid !== 1'b1 || bus.word_data !== e[j]) begin bad++; $display("FAIL ovf_drain%0d got=%b/%h want=1/%h", j, bus.word_valid, bus.word_data, e[j]); end
            tick();
        end
        total++; if (bus.word_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", bus.word_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_soft_reset;
        logic [31:0] e;
        bus.word_ready = 1'b0;
        send_word(0, e);
        for (int i = 0; i < 7; i++) send(2'b01);
        tick();
        tick();
        total++; if (bus.word_valid !== 1'b1) begin bad++; $display("FAIL srst_pre_valid got=%b want=1", bus.word_valid); end
        bus.sample_stb = 1'b1;
        soft_reset     = 1'b1;
        tick();
        bus.sample_stb = 1'b0;
        soft_reset     = 1'b0;
        total++; if (rx_count !== 11'd0) begin bad++; $display("FAIL srst_rx_count got=%0d want=0", rx_count); end
        total++; if (bus.word_valid !== 1'b0 || bus.word_data !== 32'h0) begin bad++; $display("FAIL srst_fifo got=%b/%h want=0/0", bus.word_valid, bus.word_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL srst_overflow got=%b want=0", overflow); end
        bus.word_ready = 1'b1;
        send_word(2, e);
        tick();
        total++; if (bus.word_valid !== 1'b1 || bus.word_data !== e || bus.word_first !== 1'b1) begin bad++; $display("FAIL srst_word got=%b/%h/%b want=1/%h/1", bus.word_valid, bus.word_data, bus.word_first, e); end
        total++; if (rx_count !== 11'd16) begin bad++; $display("FAIL srst_rx_after got=%0d want=16", rx_count); end
        tick();
    endtask

    task automatic test_full_pop_push;
        logic [31:0] e [5];
        do_soft_reset();
        bus.word_ready = 1'b0;
        for (int w = 0; w < 5; w++) send_word(w, e[w]);
        bus.word_ready = 1'b1;
        tick();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%b want=0", overflow); end
        for (int j = 1; j < 5; j++) begin
            total++; if (bus.word_valid !== 1'b1 || bus.word_data !== e[j]) begin bad++; $display("FAIL fpp_drain%0d got=%b/%h want=1/%h", j, bus.word_valid, bus.word_data, e[j]); end
            tick();
        end
        total++; if (bus.word_valid !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL fpp_end got=%b/%b want=0/0", bus.word_valid, overflow); end
    endtask

    task automatic test_enable;
        logic [31:0] e = '0;
        logic [1:0]  v;
        do_soft_reset();
        bus.word_ready = 1'b1;
        for (int a = 0; a < 5; a++) begin
            v = 2'((a * 3 + 1) % 4);
            e = e | (32'(v) << (2 * a));
            send(v);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) send(2'b11);
        total++; if (rx_count !== 11'd5) begin bad++; $display("FAIL en_rx_held got=%0d want=5", rx_count); end
        total++; if (bus.word_valid !== 1'b0) begin bad++; $display("FAIL en_no_word got=%b want=0", bus.word_valid); end
        enable = 1'b1;
        for (int a = 5; a < 16; a++) begin
            v = 2'((a * 3 + 1) % 4);
            e = e | (32'(v) << (2 * a));
            send(v);
        end
        total++; if (rx_count !== 11'd16) begin bad++; $display("FAIL en_rx_resume got=%0d want=16", rx_count); end
        tick();
        total++; if (bus.word_valid !== 1'b1 || bus.word_data !== e || bus.word_first !== 1'b1) begin bad++; $display("FAIL en_word got=%b/%h/%b want=1/%h/1", bus.word_valid, bus.word_data, bus.word_first, e); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_epoch();
        test_overflow();
        test_soft_reset();
        test_full_pop_push();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
